// File: rtl/softplus_vec_seq.sv
// softplus_vec_seq: walks a vector held in an input buffer through one shared
// softplus unit, one element at a time, and writes each result to an output
// buffer. Data is passed through untouched; this block only sequences.
module softplus_vec_seq #(
    parameter int unsigned N     = 16,  // data word width
    parameter int unsigned Q     = 12,  // fractional bits (carried for the datapath, unused here)
    parameter int unsigned DEPTH = 8,   // maximum vector length
    parameter int unsigned AW    = 3,   // buffer address width
    parameter int unsigned LAT   = 4    // sp_start to valid sp_y, in cycles
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rd_addr,
    input  logic [N-1:0]  rd_data,
    output logic          sp_start,
    output logic [N-1:0]  sp_x,
    input  logic [N-1:0]  sp_y,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [N-1:0]  wr_data
);

    // Wait counter only needs to reach LAT-1.
    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] CntLast = CW'(LAT - 1);
    localparam logic [AW:0]   DepthW  = (AW + 1)'(DEPTH);

    // A misconfigured instance never starts, rather than sequencing garbage.
    localparam bit ParamsOk = (Q < N) && (DEPTH >= 1) && (DEPTH <= (1 << AW)) && (LAT >= 1);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StIssue,
        StWait,
        StWrite,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [AW:0]     len_q, len_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    sp_x_q, sp_x_d;
    logic            last_elem;

    assign last_elem = ({1'b0, idx_q} == (len_q - (AW + 1)'(1)));

    // State and datapath registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            sp_x_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            sp_x_q  <= sp_x_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        sp_x_d   = sp_x_q;
        busy     = 1'b0;
        done     = 1'b0;
        sp_start = 1'b0;
        wr_en    = 1'b0;
        rd_addr  = '0;
        wr_addr  = '0;
        wr_data  = '0;
        sp_x     = sp_x_q;

        case (state_q)
            StIdle: begin
                if (req && ParamsOk) begin
                    len_d   = (len > DepthW) ? DepthW : len;
                    idx_d   = '0;
                    state_d = (len == '0) ? StDone : StRead;
                end
            end

            StRead: begin
                busy    = 1'b1;
                rd_addr = idx_q;
                state_d = StIssue;
            end

            StIssue: begin
                busy     = 1'b1;
                sp_start = 1'b1;
                // Forward the fresh operand alongside the start pulse, then hold
                // the registered copy until the next element is issued.
                sp_x     = rd_data;
                sp_x_d   = rd_data;
                cnt_d    = '0;
                state_d  = StWait;
            end

            StWait: begin
                busy  = 1'b1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CntLast) begin
                    state_d = StWrite;
                end
            end

            StWrite: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = idx_q;
                wr_data = sp_y;
                if (last_elem) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = StRead;
                end
            end

            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: doc/softplus_vec_seq.md
Name: softplus_vec_seq

Overview:
- Sequencer that applies the shared softplus_16_bit unit (Q4.12, 16-bit) element-by-element to a vector held in an input buffer, and writes results to an output buffer.
- Sits between the VAE layer controller (issues req/len) and one softplus instance. The sequencer owns that instance's start/x and samples its y after a fixed latency.

Parameters:
N, 16, data word width (matches softplus unit)
Q, 12, fractional bits (pass-through only, no arithmetic in this block)
DEPTH, 8, maximum vector length
AW, 3, buffer address width, clog2(DEPTH)
LAT, 4, cycles from sp_start pulse to valid sp_y (≥1)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-high reset
req  in  1  start vector operation; sampled only in IDLE
len  in  AW+1  element count, captured with req
busy  out  1  high while processing elements
done  out  1  one-cycle pulse after last write
rd_addr  out  AW  input buffer read address; buffer returns rd_data one cycle later
rd_data  in  N  input buffer read data
sp_start  out  1  start pulse to softplus unit
sp_x  out  N  operand to softplus unit
sp_y  in  N  softplus result
wr_en  out  1  output buffer write strobe
wr_addr  out  AW  output buffer write address
wr_data  out  N  output buffer write data

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, idx=0, wait counter=0. busy, done, sp_start, and wr_en are 0. rd_addr, sp_x, wr_addr, and wr_data are 0. Reset mid-operation aborts immediately, and no write occurs in the following cycle.
- States: IDLE, READ, ISSUE, WAIT, WRITE, DONE.
- IDLE: if req=1, latch len_r = min(len, DEPTH) and clear idx. If len_r=0, go to DONE; otherwise go to READ.
- READ (1 cycle): rd_addr=idx. Go to ISSUE.
- ISSUE (1 cycle): sp_x <= rd_data, registered and then held constant until the next ISSUE. sp_start=1 for exactly this cycle. Clear the wait counter. Go to WAIT.
- WAIT (LAT cycles): increment the counter. Leave when counter reaches LAT-1 and go to WRITE.
- WRITE (1 cycle): wr_en=1, wr_addr=idx, wr_data=sp_y. If idx==len_r-1, go to DONE; otherwise idx++ and go to READ.
- DONE (1 cycle): done=1, busy=0. Go to IDLE.
- busy=1 in READ, ISSUE, WAIT, and WRITE; 0 otherwise.
- Per-element cost: LAT+3 cycles.
- Timing: if req is sampled at edge t, the first READ occurs in cycle t+1. The last WRITE occurs in cycle t + len_r·(LAT+3). done occurs in the cycle after that. For len_r=0, done occurs in cycle t+1.
- req while not IDLE (including DONE) is ignored. req held high re-triggers on the next IDLE cycle.
- len > DEPTH is clamped to DEPTH. len is not re-sampled during an operation.
- wr_en is never asserted outside WRITE. Each address 0..len_r-1 is written exactly once, in ascending order.
- No arithmetic on data; widths pass through unchanged.

Test Plan:
1. Single element: buf[0]=0x2000, len=1, real softplus, LAT=4. Require sp_start pulse 2 cycles after req; wr_en at cycle 7 with wr_addr=0 and wr_data≈0x2208 (softplus(2.0), ±1 LSB); done at cycle 8.
2. Full vector: stub y=x+1 with LAT=4, buf[i]=0x0100·i, len=8. Require 8 writes with addresses 0..7 and data 0x0001,0x0101,…,0x0701, spaced 7 cycles apart; done 57 cycles after req; busy high throughout.
3. Zero length: len=0. Require done 1 cycle after req, no sp_start, no wr_en, and busy never high.
4. Clamp: len=12. Require exactly 8 writes (addr 0..7), then done.
5. Reset mid-op: len=8, assert rst during the WAIT of element 3. Require no further wr_en, all outputs 0, IDLE next cycle. A new req with len=2 then yields writes to addresses 0 and 1 only.
6. Ignored req: pulse req with len=3 during a len=4 run. Require exactly 4 writes and one done pulse. A held req then starts a second run immediately after IDLE.
